// File: rtl/key_seg_pkg.sv
// Shared constants for the keystroke display: control codes, segment patterns
// and the hex-digit glyph table (segments are {g,f,e,d,c,b,a}, active-low).
package key_seg_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Hex mode feeds the glyph ROM ASCII so both modes share one decoder.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational ASCII to active-low seven-segment glyph map.
module seg_glyph_rom
    import key_seg_pkg::*;
(
    input  logic [7:0] ascii_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
            seg_o = HEX_SEG[ascii_i[3:0]];
        end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                     (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
            // 'A'..'F' and 'a'..'f' share low nibbles 1..6, i.e. table entries 10..15
            seg_o = HEX_SEG[ascii_i[3:0] + 4'd9];
        end else begin
            case (ascii_i)
                8'h48:   seg_o = 7'h09; // H
                8'h4C:   seg_o = 7'h47; // L
                8'h50:   seg_o = 7'h0C; // P
                8'h55:   seg_o = 7'h41; // U
                8'h72:   seg_o = 7'h2F; // r
                8'h6E:   seg_o = 7'h2B; // n
                8'h6F:   seg_o = 7'h23; // o
                8'h74:   seg_o = 7'h07; // t
                8'h79:   seg_o = 7'h11; // y
                8'h20:   seg_o = SEG_BLANK;
                default: seg_o = (ascii_i > 8'h20 && ascii_i <= 8'h7E) ? SEG_DASH : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/key_seg_display.sv
// Keystroke history with a scrollable, time-multiplexed window onto a
// common-anode seven-segment bank, plus a hex dump of the newest byte.
module key_seg_display
    import key_seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int HIST_DEPTH  = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      key_ascii,
    input  logic                            key_valid,
    input  logic                            scroll_up,
    input  logic                            scroll_down,
    input  logic                            hex_mode,
    output logic [DIGITS-1:0]               an,
    output logic [6:0]                      seg,
    output logic                            dp,
    output logic [$clog2(HIST_DEPTH+1)-1:0] fill_count,
    output logic                            overflow
);

    localparam int CW = $clog2(HIST_DEPTH + 1);
    localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [7:0]        hist_q [HIST_DEPTH];
    logic              wr_en;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     fill_q, fill_d;
    logic [CW-1:0]     offset_q, offset_d, max_offset;
    logic              ovf_q, ovf_d;
    logic [RW-1:0]     refresh_q, refresh_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic [31:0]       pos;
    logic [PW-1:0]     newest_ptr, rd_ptr;
    logic [7:0]        newest_byte, rom_ascii;
    logic [6:0]        rom_seg;
    logic              show;

    assign max_offset = (fill_q > CW'(DIGITS)) ? fill_q - CW'(DIGITS) : '0;

    // A strobed key always takes priority over a scroll request in the same cycle.
    always_comb begin
        wptr_d   = wptr_q;
        fill_d   = fill_q;
        offset_d = offset_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        if (key_valid) begin
            if (key_ascii == ASCII_BS) begin
                if (fill_q != '0) begin
                    wptr_d   = (wptr_q == '0) ? PW'(HIST_DEPTH - 1) : wptr_q - 1'b1;
                    fill_d   = fill_q - 1'b1;
                    offset_d = '0;
                end
            end else if (key_ascii == ASCII_ESC) begin
                wptr_d   = '0;
                fill_d   = '0;
                offset_d = '0;
                ovf_d    = 1'b0;
            end else if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) begin
                wr_en    = 1'b1;
                wptr_d   = (wptr_q == PW'(HIST_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
                offset_d = '0;
                if (fill_q == CW'(HIST_DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end else if (scroll_up && !scroll_down) begin
            if (offset_q < max_offset) offset_d = offset_q + 1'b1;
        end else if (scroll_down && !scroll_up) begin
            if (offset_q != '0) offset_d = offset_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) hist_q[wptr_q] <= key_ascii;
    end

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        digit_d   = digit_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
        end
    end

    // Digit d shows history position offset+d counted back from the newest entry.
    always_comb begin
        pos         = 32'(offset_q) + 32'(digit_q);
        newest_ptr  = PW'((32'(wptr_q) + 32'(HIST_DEPTH) - 32'd1) % 32'(HIST_DEPTH));
        rd_ptr      = PW'((32'(newest_ptr) + 32'(HIST_DEPTH) - pos) % 32'(HIST_DEPTH));
        newest_byte = hist_q[newest_ptr];
        rom_ascii   = hist_q[rd_ptr];
        show        = pos < 32'(fill_q);
        if (hex_mode) begin
            rom_ascii = nibble_to_ascii((digit_q == '0) ? newest_byte[3:0] : newest_byte[7:4]);
            show      = (fill_q != '0) && (32'(digit_q) < 32'd2);
        end
        an_d  = ~(DIGITS'(1) << digit_q);
        seg_d = show ? rom_seg : SEG_BLANK;
        // The oldest-char marker only makes sense while characters are displayed.
        dp_d  = !(!hex_mode && fill_q != '0 && pos == 32'(fill_q) - 32'd1);
    end

    seg_glyph_rom u_glyph (
        .ascii_i (rom_ascii),
        .seg_o   (rom_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            fill_q    <= '0;
            offset_q  <= '0;
            ovf_q     <= 1'b0;
            refresh_q <= '0;
            digit_q   <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            fill_q    <= fill_d;
            offset_q  <= offset_d;
            ovf_q     <= ovf_d;
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign fill_count = fill_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_key_seg_display.sv
// Directed plus randomized bench for key_seg_display, checked against a
// queue-based history model and a segment-letter glyph description.
module tb_key_seg_display;

    localparam int DIGITS = 4;
    localparam int HD     = 8;
    localparam int RD     = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        key_ascii = 8'h00;
    logic              key_valid = 1'b0;
    logic              scroll_up = 1'b0;
    logic              scroll_down = 1'b0;
    logic              hex_mode = 1'b0;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;
    logic [3:0]        fill_count;
    logic              overflow;

    int checks = 0;
    int failures = 0;

    logic [7:0] hist[$];
    bit         m_ovf = 1'b0;
    int         m_off = 0;

    key_seg_display #(.DIGITS(DIGITS), .HIST_DEPTH(HD), .REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_ascii   (key_ascii),
        .key_valid   (key_valid),
        .scroll_up   (scroll_up),
        .scroll_down (scroll_down),
        .hex_mode    (hex_mode),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .fill_count  (fill_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Glyphs described by which segments are lit, then turned into active-low {g..a}.
    function automatic logic [6:0] glyph(input logic [7:0] c);
        string lit;
        logic [6:0] s;
        case (c)
            "0": lit = "abcdef";   "1": lit = "bc";      "2": lit = "abdeg";
            "3": lit = "abcdg";    "4": lit = "bcfg";    "5": lit = "acdfg";
            "6": lit = "acdefg";   "7": lit = "abc";     "8": lit = "abcdefg";
            "9": lit = "abcdfg";
            "A", "a": lit = "abcefg";  "B", "b": lit = "cdefg";
            "C", "c": lit = "adef";    "D", "d": lit = "bcdeg";
            "E", "e": lit = "adefg";   "F", "f": lit = "aefg";
            "H": lit = "bcefg";  "L": lit = "def";   "P": lit = "abefg";
            "U": lit = "bcdef";  "r": lit = "eg";    "n": lit = "ceg";
            "o": lit = "cdeg";   "t": lit = "defg";  "y": lit = "bcdfg";
            " ": lit = "";
            default: lit = "g";
        endcase
        s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) s[lit[i] - 8'h61] = 1'b0;
        return s;
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        string hx;
        logic [7:0] nb;
        hx = "0123456789ABCDEF";
        if (hex_mode) begin
            if (hist.size() == 0 || d > 1) return 7'h7F;
            nb = hist[hist.size() - 1];
            return glyph(hx[(d == 0) ? int'(nb[3:0]) : int'(nb[7:4])]);
        end
        if (m_off + d < hist.size()) return glyph(hist[hist.size() - 1 - (m_off + d)]);
        return 7'h7F;
    endfunction

    function automatic logic exp_dp(input int d);
        return !(hist.size() > 0 && m_off + d == hist.size() - 1);
    endfunction

    function automatic void model_key(input logic [7:0] c);
        if (c == 8'h08) begin
            if (hist.size() > 0) begin
                void'(hist.pop_back());
                m_off = 0;
            end
        end else if (c == 8'h1B) begin
            hist.delete();
            m_ovf = 1'b0;
            m_off = 0;
        end else if (c >= 8'h20 && c <= 8'h7E) begin
            if (hist.size() == HD) begin
                void'(hist.pop_front());
                m_ovf = 1'b1;
            end
            hist.push_back(c);
            m_off = 0;
        end
    endfunction

    function automatic void model_scroll(input bit up, input bit down);
        int mx;
        mx = (hist.size() > DIGITS) ? hist.size() - DIGITS : 0;
        if (up && !down && m_off < mx) m_off++;
        if (down && !up && m_off > 0) m_off--;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] c, input bit with_scroll);
        key_ascii = c;
        key_valid = 1'b1;
        scroll_up = with_scroll;
        tick();
        key_valid = 1'b0;
        scroll_up = 1'b0;
        model_key(c);
        $display("key 0x%02h%s fill=%0d off=%0d", c, with_scroll ? " +scroll" : "", hist.size(), m_off);
    endtask

    task automatic send_scroll(input bit up, input bit down);
        scroll_up   = up;
        scroll_down = down;
        tick();
        scroll_up   = 1'b0;
        scroll_down = 1'b0;
        model_scroll(up, down);
        $display("scroll up=%0d down=%0d off=%0d", up, down, m_off);
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) send_key(s[i], 1'b0);
    endtask

    // Scans one full refresh cycle in digit order and compares every digit.
    task automatic check_display(input string tag);
        logic [DIGITS-1:0] want;
        int budget;
        tick();
        chk({tag, ".fill"}, 32'(fill_count), 32'(hist.size()));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        for (int d = 0; d < DIGITS; d++) begin
            want   = ~(DIGITS'(1) << d);
            budget = (d == 0) ? 2 * DIGITS * RD : RD + 1;
            while (an !== want && budget > 0) begin
                tick();
                budget--;
            end
            chk($sformatf("%s.an%0d", tag, d), 32'(an), 32'(want));
            chk($sformatf("%s.seg%0d", tag, d), 32'(seg), 32'(exp_seg(d)));
            if (!hex_mode) chk($sformatf("%s.dp%0d", tag, d), 32'(dp), 32'(exp_dp(d)));
        end
    endtask

    initial begin
        string cs;
        int op;
        logic [7:0] c;
        cs = "0123456789ABCDEFabcdefHLPUrnoty !#xz~";

        // Reset state.
        repeat (3) tick();
        chk("rst.an", 32'(an), 32'hF);
        chk("rst.seg", 32'(seg), 32'h7F);
        chk("rst.dp", 32'(dp), 32'h1);
        chk("rst.fill", 32'(fill_count), 32'h0);
        chk("rst.ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
        check_display("empty");

        // 1: HELP walks P,L,E,H from right to left.
        type_str("HELP");
        check_display("help");

        // 2: overflow drops the oldest char; scroll to the oldest; ESC clears.
        type_str("ABCDEFGHI");
        check_display("ovf");
        repeat (5) send_scroll(1'b1, 1'b0);
        check_display("ovf_scroll");
        send_key(8'h1B, 1'b0);
        check_display("esc");

        // 3: scroll clamps at fill-DIGITS; a new key snaps back.
        type_str("12345");
        repeat (3) send_scroll(1'b1, 1'b0);
        check_display("clamp");
        send_scroll(1'b1, 1'b1);
        check_display("both_scroll");
        send_key("6", 1'b0);
        check_display("snap");

        // 4: backspace on empty is ignored; then partial delete.
        send_key(8'h1B, 1'b0);
        send_key(8'h08, 1'b0);
        check_display("bs_empty");
        type_str("AB");
        send_key(8'h08, 1'b0);
        check_display("bs");

        // 5: hex dump of 0x5A.
        send_key("Z", 1'b0);
        hex_mode = 1'b1;
        check_display("hex");
        hex_mode = 1'b0;

        // 6: reset between edges blanks at once; scanning restarts at digit 0.
        check_display("pre_rst");
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst.an", 32'(an), 32'hF);
        chk("mid_rst.seg", 32'(seg), 32'h7F);
        chk("mid_rst.dp", 32'(dp), 32'h1);
        chk("mid_rst.fill", 32'(fill_count), 32'h0);
        hist.delete();
        m_ovf = 1'b0;
        m_off = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("resume.an0", 32'(an), 32'hE);
        @(negedge clk);
        repeat (4) tick();
        chk("resume.an1", 32'(an), 32'hD);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 11);
            hex_mode = ($urandom_range(0, 9) == 0);
            if (op <= 4) begin
                c = cs[$urandom_range(0, cs.len() - 1)];
                send_key(c, 1'b0);
            end else if (op == 5) begin
                send_key(8'h08, 1'b0);
            end else if (op == 6) begin
                send_key(($urandom_range(0, 3) == 0) ? 8'h1B : 8'h07, 1'b0);
            end else if (op <= 8) begin
                send_scroll(1'b1, 1'b0);
            end else if (op == 9) begin
                send_scroll(1'b0, 1'b1);
            end else begin
                c = cs[$urandom_range(0, cs.len() - 1)];
                send_key(c, 1'b1);
            end
            check_display($sformatf("rnd%0d", it));
        end
        hex_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
